// File: rtl/ts_mem_ctrl.sv
// Timestamp ring-buffer controller.
// Owns a simple-dual-port RAM: the read port is dedicated to the host
// (one-cycle latency, no stall), and the write port is shared between the
// timestamp producer and a zero-fill clear sweep.
module ts_mem_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic [DATA_W-1:0] host_data_o,
    input  logic              host_pop_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [DATA_W-1:0]   host_data_q;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;

    logic                full;
    logic                accept;
    logic                pop_ok;

    // Next-state, pointer bookkeeping and write-port arbitration.
    // A clear pulse wins over everything; a producer write on that same
    // cycle is dropped so the zeroed pointers stay consistent.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sweep_d   = sweep_q;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr_q;
        ram_wdata = wr_data_i;

        full       = (count_q == CNT_FULL);
        wr_ready_o = (state_q == RUN) && (OVERWRITE || !full);
        accept     = wr_valid_i && wr_ready_o;
        pop_ok     = host_pop_i && (count_q != '0) && (state_q != CLEAR);

        case (state_q)
            IDLE: if (enable_i)  state_d = RUN;
            RUN:  if (!enable_i) state_d = IDLE;
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_q;
                ram_wdata = '0;
                sweep_d   = sweep_q + PTR_ONE;
                if (sweep_q == PTR_LAST) state_d = enable_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d  = CLEAR;
            sweep_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (accept) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr_q;
            ram_wdata = wr_data_i;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            if (full) begin
                // Overwrite the oldest entry; a concurrent pop folds into this
                // single read-pointer advance.
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                ovf_d    = 1'b1;
            end else if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end
    end

    // Control state registers; reset aborts any sweep in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sweep_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sweep_q  <= sweep_d;
        end
    end

    // Host read register: registered RAM output, old data on a same-address write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) host_data_q <= '0;
        else          host_data_q <= ram[host_addr_i];
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    assign host_data_o = host_data_q;
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = (state_q == CLEAR);

endmodule
